// File: rtl/sensor_debounce_pkg.sv
// Shared definitions for the sensor conditioning path: FSM encoding and default debounce lengths.
package sensor_debounce_pkg;

  typedef enum logic [1:0] {
    StStableLo = 2'd0,
    StCheckHi  = 2'd1,
    StStableHi = 2'd2,
    StCheckLo  = 2'd3
  } state_e;

  // 1 ms at the 12 MHz board clock.
  localparam int unsigned DebounceCycles1Ms12Mhz = 12000;
  localparam int unsigned DebounceCyclesDefault  = 1000;

  function automatic state_e stable_state(bit lvl);
    return lvl ? StStableHi : StStableLo;
  endfunction

endpackage

// File: rtl/sensor_debounce_sync_2ff.sv
// Two-flop synchroniser for an asynchronous input pin, with a programmable reset value.
module sensor_debounce_sync_2ff #(
  parameter bit INI = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q <= INI;
      s2_q <= INI;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/sensor_debounce.sv
// Debounces one raw sensor pin into a clean level plus one-cycle rise/fall/change strobes.
module sensor_debounce
  import sensor_debounce_pkg::*;
#(
  parameter bit          INI             = 1'b0,
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic level,
  output logic change,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam state_e               StInit  = stable_state(INI);

  logic                 s2;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;

  sensor_debounce_sync_2ff #(
    .INI(INI)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (raw),
    .q   (s2)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StInit;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The first differing sample counts as sample one, so a length of 1 accepts straight away.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      StStableLo: begin
        if (s2) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = StStableHi;
            rise_d  = 1'b1;
          end else begin
            state_d = StCheckHi;
            cnt_d   = CntOne;
          end
        end
      end
      StCheckHi: begin
        if (!s2) begin
          state_d = StStableLo;
        end else if (cnt_q == CntLast) begin
          state_d = StStableHi;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStableHi: begin
        if (!s2) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = StStableLo;
            fall_d  = 1'b1;
          end else begin
            state_d = StCheckLo;
            cnt_d   = CntOne;
          end
        end
      end
      StCheckLo: begin
        if (s2) begin
          state_d = StStableHi;
        end else if (cnt_q == CntLast) begin
          state_d = StStableLo;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StInit;
    endcase
  end

  assign level  = (state_q == StStableHi) || (state_q == StCheckLo);
  assign busy   = (state_q == StCheckHi) || (state_q == StCheckLo);
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign change = rise_q | fall_q;

endmodule

// File: tb/tb_sensor_debounce.sv
// Self-checking bench: three debouncer configurations against a run-length reference model.
module tb_sensor_debounce;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic raw [3];
  logic lvl [3];
  logic chg [3];
  logic ris [3];
  logic fal [3];
  logic bsy [3];

  int total = 0;
  int bad = 0;

  // Reference state: synchroniser delay line, accepted level, length of current differing run.
  logic m_s1 [3];
  logic m_s2 [3];
  logic m_lvl [3];
  logic m_rise [3];
  logic m_fall [3];
  int unsigned m_run [3];

  always #5 clk = ~clk;

  function automatic logic ini_of(int i);
    return (i == 1);
  endfunction

  function automatic int unsigned d_of(int i);
    return (i == 2) ? 1 : 4;
  endfunction

  sensor_debounce #(.INI(1'b0), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .rstn(rstn), .raw(raw[0]), .level(lvl[0]), .change(chg[0]),
    .rise(ris[0]), .fall(fal[0]), .busy(bsy[0])
  );
  sensor_debounce #(.INI(1'b1), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .rstn(rstn), .raw(raw[1]), .level(lvl[1]), .change(chg[1]),
    .rise(ris[1]), .fall(fal[1]), .busy(bsy[1])
  );
  sensor_debounce #(.INI(1'b0), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(16)) dut2 (
    .clk(clk), .rstn(rstn), .raw(raw[2]), .level(lvl[2]), .change(chg[2]),
    .rise(ris[2]), .fall(fal[2]), .busy(bsy[2])
  );

  // A level flips once the synchronised input has disagreed with it for D consecutive samples.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++) begin
        m_s1[i]   <= ini_of(i);
        m_s2[i]   <= ini_of(i);
        m_lvl[i]  <= ini_of(i);
        m_rise[i] <= 1'b0;
        m_fall[i] <= 1'b0;
        m_run[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_rise[i] <= 1'b0;
        m_fall[i] <= 1'b0;
        if (m_s2[i] != m_lvl[i]) begin
          if (m_run[i] + 1 == d_of(i)) begin
            m_lvl[i]  <= ~m_lvl[i];
            m_rise[i] <= ~m_lvl[i];
            m_fall[i] <= m_lvl[i];
            m_run[i]  <= 0;
          end else begin
            m_run[i] <= m_run[i] + 1;
          end
        end else begin
          m_run[i] <= 0;
        end
        m_s2[i] <= m_s1[i];
        m_s1[i] <= raw[i];
      end
    end
  end

  task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (level,rise,fall,change,busy) at %0t",
               name, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every DUT against the model.
  task automatic cyc();
    logic [4:0] got, exp;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      got = {lvl[i], ris[i], fal[i], chg[i], bsy[i]};
      exp = {m_lvl[i], m_rise[i], m_fall[i], m_rise[i] | m_fall[i], m_run[i] != 0};
      chk($sformatf("model_dut%0d", i), got, exp);
    end
  endtask

  task automatic cycn(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    int rise_cnt, fall_cnt, busy_seen;
    logic smp [64];

    raw[0] = 1'b1;
    raw[1] = 1'b0;
    raw[2] = 1'b1;
    #1 rstn = 1'b0;

    // Reset with raw opposite to INI: outputs sit at INI, all strobes quiet.
    cycn(3);
    chk("reset_dut0", {lvl[0], ris[0], fal[0], chg[0], bsy[0]}, 5'b00000);
    chk("reset_dut1", {lvl[1], ris[1], fal[1], chg[1], bsy[1]}, 5'b10000);
    chk("reset_dut2", {lvl[2], ris[2], fal[2], chg[2], bsy[2]}, 5'b00000);
    raw[0] = 1'b0;
    raw[1] = 1'b1;
    raw[2] = 1'b0;
    #2 rstn = 1'b1;
    cycn(4);

    // Clean 0->1 step with D=4: level rises on the 6th edge after the step is first sampled.
    raw[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      if (k == 5) chk("step_before", {lvl[0], ris[0], chg[0]}, 3'b000);
      if (k == 6) chk("step_accept", {lvl[0], ris[0], fal[0], chg[0]}, 4'b1101);
      if (k == 7) chk("step_after", {lvl[0], ris[0], chg[0]}, 3'b100);
    end
    raw[0] = 1'b0;
    cycn(10);
    chk("step_back_low", {3'b000, lvl[0]}, 4'b0000);

    // Three-sample glitch: busy seen, no acceptance.
    busy_seen = 0;
    rise_cnt = 0;
    raw[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (k == 3) raw[0] = 1'b0;
      busy_seen += bsy[0];
      rise_cnt += ris[0] + chg[0];
    end
    chk("glitch_busy", 5'(busy_seen != 0), 5'd1);
    chk("glitch_nopulse", 5'(rise_cnt), 5'd0);
    chk("glitch_level", {4'b0, lvl[0]}, 5'd0);

    // Bounce 1,0,1,0,0,0,0,0 on the INI=1 unit: exactly one fall.
    fall_cnt = 0;
    rise_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      raw[1] = (k == 0 || k == 2);
      cyc();
      fall_cnt += fal[1];
      rise_cnt += ris[1];
    end
    chk("bounce_falls", 5'(fall_cnt), 5'd1);
    chk("bounce_rises", 5'(rise_cnt), 5'd0);
    chk("bounce_level", {4'b0, lvl[1]}, 5'd0);

    // Asynchronous reset while counting toward a rise (counter at 2).
    raw[0] = 1'b1;
    cycn(4);
    chk("midcount_busy", {3'b0, lvl[0], bsy[0]}, 5'b00001);
    #2 rstn = 1'b0;
    #1;
    chk("async_dut0", {lvl[0], ris[0], fal[0], chg[0], bsy[0]}, 5'b00000);
    chk("async_dut1", {lvl[1], ris[1], fal[1], chg[1], bsy[1]}, 5'b10000);
    raw[0] = 1'b0;
    raw[1] = 1'b1;
    cycn(2);
    #2 rstn = 1'b1;
    rise_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      rise_cnt += ris[0] + chg[0];
    end
    chk("release_nopulse", 5'(rise_cnt), 5'd0);

    // D=1 square wave, period 8: level is the value sampled two edges earlier.
    for (int k = 0; k < 48; k++) begin
      cyc();
      smp[k] = raw[2];
      if (k >= 3) begin
        chk("sq_level", {4'b0, lvl[2]}, {4'b0, smp[k-2]});
        chk("sq_pulses", {3'b0, ris[2], fal[2]},
            {3'b0, smp[k-2] & ~smp[k-3], ~smp[k-2] & smp[k-3]});
      end
      raw[2] = 1'(((k + 1) >> 2) & 1);
    end

    // Random stimulus with one mid-run asynchronous reset.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(7) == 0) raw[0] = ~raw[0];
      if ($urandom_range(4) == 0) raw[1] = ~raw[1];
      if ($urandom_range(1) == 0) raw[2] = ~raw[2];
      if (k == 700) begin
        #3 rstn = 1'b0;
        cycn(2);
        #1 rstn = 1'b1;
      end
      cyc();
    end

    // Every-cycle toggling never gets through the D=4 filters.
    rise_cnt = 0;
    cycn(12);
    for (int k = 0; k < 40; k++) begin
      raw[0] = ~raw[0];
      raw[1] = ~raw[1];
      cyc();
      if (k >= 4) rise_cnt += chg[0] + chg[1];
    end
    chk("toggle_nochange", 5'(rise_cnt), 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sensor_debounce.md
Name: sensor_debounce

Overview:
- Conditions one raw hexapod sensor line (bumper, IR, light switch) before it reaches the basic-behaviour latches.
- Synchronises the asynchronous pin and filters bounce with a stability counter.
- Emits a clean level plus one-cycle change strobes.
- Drives the d/load pair of the downstream D-latch stage directly: d = level, load = change.

Parameters:
- INI, 0: reset/initial value of the filtered level (0 or 1); also the assumed prior sensor state.
- DEBOUNCE_CYCLES, 1000: consecutive stable synchronised samples required to accept a new level; legal range 1 to 2^CNT_WIDTH-1.
- CNT_WIDTH, 16: width of the stability counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- raw  in  1  unsynchronised sensor pin.
- level  out  1  debounced sensor level (to latch d).
- change  out  1  one-cycle pulse when level toggles (to latch load).
- rise  out  1  one-cycle pulse on accepted 0->1.
- fall  out  1  one-cycle pulse on accepted 1->0.
- busy  out  1  high while a candidate transition is being counted.

Behaviour:
- Reset:
  - rstn low asynchronously forces both synchroniser flops to INI, counter to 0, state to STABLE_INI (STABLE_LO if INI=0, else STABLE_HI).
  - level=INI, change=rise=fall=busy=0.
  - Release is synchronous in effect: the first update happens at the first clk edge with rstn high.
- Synchroniser:
  - Two-flop chain raw -> s1 -> s2. Only s2 is used by the FSM.
  - Latency from raw to s2 is 2 cycles.
- FSM states:
  - STABLE_LO: level=0. If s2=1, go to CHECK_HI, counter<=1.
  - CHECK_HI: busy=1. If s2=0, return to STABLE_LO, counter<=0, no pulse. Else if counter==DEBOUNCE_CYCLES-1, go to STABLE_HI. Else counter+1.
  - STABLE_HI: level=1. If s2=0, go to CHECK_LO, counter<=1.
  - CHECK_LO: symmetric to CHECK_HI.
- Acceptance timing:
  - On entering STABLE_HI: level<=1, rise=1 and change=1 in the same cycle that level first reads 1, for exactly one cycle.
  - On entering STABLE_LO from CHECK_LO: fall=1, change=1 likewise.
- Latency:
  - A clean step on raw produces the level change DEBOUNCE_CYCLES+2 clk edges after the first sampling edge.
  - With DEBOUNCE_CYCLES=1, the level follows s2 one cycle later.
- Glitches: any glitch shorter than DEBOUNCE_CYCLES samples produces no output activity. busy may pulse during it.
- Pulse mutual exclusion: rise and fall are never high together; change = rise | fall at all times.
- Counter:
  - Never wraps; it saturates logically because the CHECK exit occurs at DEBOUNCE_CYCLES-1.
  - Counter is don't-care in STABLE states and is held at 0 there.
- Reset mid-count: pending transition discarded, no pulse emitted, level returns to INI.
- Raw toggling every cycle indefinitely: level held, change never asserted.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (2-bit: STABLE_LO=0, CHECK_HI=1, STABLE_HI=2, CHECK_LO=3).
  - Default DEBOUNCE_CYCLES values for 12 MHz board clock (1 ms = 12000).
- One sub-module is natural: sync_2ff (two-flop synchroniser with INI and async active-low reset), reused for every external pin in the design.

Test Plan:
- Reset with INI=0, then INI=1; raw held at opposite value during reset -> level equals INI throughout reset; all pulses 0; busy 0.
- DEBOUNCE_CYCLES=4, raw 0->1 clean step -> level rises exactly 6 edges after step sample; rise=change=1 for one cycle; fall=0.
- DEBOUNCE_CYCLES=4, raw high for 3 cycles then low -> busy seen high, level stays 0, no rise/change pulse.
- DEBOUNCE_CYCLES=4, level=1, raw bounces 1,0,1,0,0,0,0,0 -> single fall and change pulse after the final 4-sample low run; no extra pulses.
- rstn asserted asynchronously (mid-cycle) during CHECK_HI with counter=2 -> outputs return to INI immediately without waiting for clk; no pulse after release while raw=0.
- DEBOUNCE_CYCLES=1, raw square wave period 8 cycles -> level follows raw delayed 3 edges; rise/fall alternate, one pulse per edge; change equals rise|fall every cycle.
